// File: rtl/oddpipe_wb_scheduler.sv
// Odd-pipe write-back scheduler: delays each accepted result by its unit latency onto one write port.
// Optional operand forwarding is enabled by defining ODDPIPE_WB_FWD_EN.
module oddpipe_wb_scheduler #(
   parameter int DEPTH  = 7,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] issue_rt_addr,
   input  logic [DATA_W-1:0] issue_rt_value,
   input  logic [3:0]        issue_latency,
   input  logic [2:0]        issue_unit_id,
   input  logic              issue_reg_write,
   input  logic              flush,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_rt_addr,
   output logic [DATA_W-1:0] wb_rt_value,
   output logic [2:0]        wb_unit_id,
   output logic [2:0]        inflight_count,
   output logic              lat_err,
   input  logic [ADDR_W-1:0] fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_value
);

   localparam logic [3:0] LP_DEPTH = 4'(DEPTH);

   logic              r_live  [1:DEPTH];
   logic [3:0]        r_rem   [1:DEPTH];
   logic [ADDR_W-1:0] r_addr  [1:DEPTH];
   logic [DATA_W-1:0] r_value [1:DEPTH];
   logic [2:0]        r_unit  [1:DEPTH];
   logic              r_rw    [1:DEPTH];

   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [DATA_W-1:0] r_wb_value;
   logic [2:0]        r_wb_unit;
   logic              r_lat_err;

   logic [DEPTH:1]    w_coll;
   logic [DEPTH:1]    w_ret;
   logic              w_lat_ok;
   logic              w_ready;
   logic              w_accept;
   logic              w_direct;
   logic              w_sel_found;
   logic              w_sel_rw;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_value;
   logic [2:0]        w_sel_unit;
   logic [2:0]        w_count;

   // A stage with rem == latency would reach zero on the same edge as the new entry.
   genvar gi;
   generate
      for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
         assign w_coll[gi] = r_live[gi] && (r_rem[gi] == issue_latency);
         assign w_ret[gi]  = r_live[gi] && (r_rem[gi] == 4'd1);
      end
   endgenerate

   assign w_lat_ok = (issue_latency != 4'd0) && (issue_latency <= LP_DEPTH);
   assign w_ready  = !reset && !flush && w_lat_ok && !(|w_coll);
   assign w_accept = issue_valid && w_ready;
   assign w_direct = w_accept && (issue_latency == 4'd1);

   always_comb begin
      w_sel_found = 1'b0;
      w_sel_rw    = 1'b0;
      w_sel_addr  = '0;
      w_sel_value = '0;
      w_sel_unit  = '0;
      w_count     = '0;
      if (w_direct) begin
         w_sel_found = 1'b1;
         w_sel_rw    = issue_reg_write;
         w_sel_addr  = issue_rt_addr;
         w_sel_value = issue_rt_value;
         w_sel_unit  = issue_unit_id;
      end
      for (int i = 1; i <= DEPTH; i++) begin
         w_count = w_count + 3'(r_live[i]);
         if (w_ret[i]) begin
            w_sel_found = 1'b1;
            w_sel_rw    = r_rw[i];
            w_sel_addr  = r_addr[i];
            w_sel_value = r_value[i];
            w_sel_unit  = r_unit[i];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= DEPTH; i++) begin
            r_live[i] <= 1'b0;
            r_rem[i]  <= 4'd0;
         end
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_value <= '0;
         r_wb_unit  <= '0;
         r_lat_err  <= 1'b0;
      end else begin
         r_live[1] <= w_accept && !w_direct;
         r_rem[1]  <= issue_latency - 4'd1;
         for (int i = 1; i < DEPTH; i++) begin
            r_live[i+1] <= r_live[i] && !w_ret[i] && !flush;
            r_rem[i+1]  <= r_rem[i] - 4'd1;
         end
         r_wb_valid <= !flush && w_sel_found && w_sel_rw;
         if (!flush && w_sel_found) begin
            r_wb_addr  <= w_sel_addr;
            r_wb_value <= w_sel_value;
            r_wb_unit  <= w_sel_unit;
         end
         if (issue_valid && !w_lat_ok)
            r_lat_err <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      r_addr[1]  <= issue_rt_addr;
      r_value[1] <= issue_rt_value;
      r_unit[1]  <= issue_unit_id;
      r_rw[1]    <= issue_reg_write;
      for (int i = 1; i < DEPTH; i++) begin
         r_addr[i+1]  <= r_addr[i];
         r_value[i+1] <= r_value[i];
         r_unit[i+1]  <= r_unit[i];
         r_rw[i+1]    <= r_rw[i];
      end
   end

`ifdef ODDPIPE_WB_FWD_EN
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_value;

   // Scan oldest to youngest so the lowest-numbered matching stage wins.
   always_comb begin
      w_fwd_hit   = 1'b0;
      w_fwd_value = '0;
      if (r_wb_valid && (r_wb_addr == fwd_addr)) begin
         w_fwd_hit   = 1'b1;
         w_fwd_value = r_wb_value;
      end
      for (int i = DEPTH; i >= 1; i--) begin
         if (r_live[i] && r_rw[i] && (r_addr[i] == fwd_addr)) begin
            w_fwd_hit   = 1'b1;
            w_fwd_value = r_value[i];
         end
      end
   end

   assign fwd_hit   = w_fwd_hit;
   assign fwd_value = w_fwd_value;
`else
   assign fwd_hit   = 1'b0 & (|fwd_addr);
   assign fwd_value = '0;
`endif

   assign issue_ready    = w_ready;
   assign wb_valid       = r_wb_valid;
   assign wb_rt_addr     = r_wb_addr;
   assign wb_rt_value    = r_wb_value;
   assign wb_unit_id     = r_wb_unit;
   assign inflight_count = w_count;
   assign lat_err        = r_lat_err;

endmodule

// File: tb/tb_oddpipe_wb_scheduler.sv
// Directed self-checking bench for oddpipe_wb_scheduler; forwarding checks follow ODDPIPE_WB_FWD_EN.
module tb_oddpipe_wb_scheduler;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         issue_valid = 1'b0;
   logic         issue_ready;
   logic [6:0]   issue_rt_addr = '0;
   logic [127:0] issue_rt_value = '0;
   logic [3:0]   issue_latency = '0;
   logic [2:0]   issue_unit_id = '0;
   logic         issue_reg_write = 1'b0;
   logic         flush = 1'b0;
   logic         wb_valid;
   logic [6:0]   wb_rt_addr;
   logic [127:0] wb_rt_value;
   logic [2:0]   wb_unit_id;
   logic [2:0]   inflight_count;
   logic         lat_err;
   logic [6:0]   fwd_addr = '0;
   logic         fwd_hit;
   logic [127:0] fwd_value;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};

   oddpipe_wb_scheduler dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rt_addr(issue_rt_addr), .issue_rt_value(issue_rt_value),
      .issue_latency(issue_latency), .issue_unit_id(issue_unit_id),
      .issue_reg_write(issue_reg_write), .flush(flush),
      .wb_valid(wb_valid), .wb_rt_addr(wb_rt_addr), .wb_rt_value(wb_rt_value),
      .wb_unit_id(wb_unit_id), .inflight_count(inflight_count), .lat_err(lat_err),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_value(fwd_value)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic [3:0] lat, input logic [6:0] addr,
                        input logic [127:0] val, input logic rw);
      issue_valid     = 1'b1;
      issue_latency   = lat;
      issue_rt_addr   = addr;
      issue_rt_value  = val;
      issue_unit_id   = 3'd5;
      issue_reg_write = rw;
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ready", 128'(issue_ready), 128'd0);
      chk("rst_wb_valid", 128'(wb_valid), 128'd0);
      chk("rst_wb_addr", 128'(wb_rt_addr), 128'd0);
      chk("rst_inflight", 128'(inflight_count), 128'd0);
      chk("rst_lat_err", 128'(lat_err), 128'd0);
      chk("rst_fwd_hit", 128'(fwd_hit), 128'd0);
      @(negedge clock);
      reset = 1'b0;

      // Latency 4: wb strobe after the 4th edge
      offer(4'd4, 7'h12, PAT_A5, 1'b1);
      chk("l4_ready", 128'(issue_ready), 128'd1);
      tick(); issue_valid = 1'b0;
      chk("l4_cnt_e1", 128'(inflight_count), 128'd1);
      chk("l4_wb_e1", 128'(wb_valid), 128'd0);
      tick();
      chk("l4_cnt_e2", 128'(inflight_count), 128'd1);
      chk("l4_wb_e2", 128'(wb_valid), 128'd0);
      tick();
      chk("l4_cnt_e3", 128'(inflight_count), 128'd1);
      chk("l4_wb_e3", 128'(wb_valid), 128'd0);
      tick();
      chk("l4_cnt_e4", 128'(inflight_count), 128'd0);
      chk("l4_wb_e4", 128'(wb_valid), 128'd1);
      chk("l4_wb_addr", 128'(wb_rt_addr), 128'h12);
      chk("l4_wb_value", wb_rt_value, PAT_A5);
      chk("l4_wb_unit", 128'(wb_unit_id), 128'd5);
      tick();
      chk("l4_wb_e5", 128'(wb_valid), 128'd0);

      // Collision: L4 then L3 stalls one cycle
      offer(4'd4, 7'h01, 128'd1, 1'b1);
      tick();
      offer(4'd3, 7'h02, 128'd2, 1'b1);
      chk("col_stall", 128'(issue_ready), 128'd0);
      tick();
      chk("col_ready", 128'(issue_ready), 128'd1);
      tick(); issue_valid = 1'b0;
      chk("col_cnt", 128'(inflight_count), 128'd2);
      tick();
      chk("col_wb1", 128'(wb_valid), 128'd1);
      chk("col_wb1_addr", 128'(wb_rt_addr), 128'h01);
      chk("col_cnt1", 128'(inflight_count), 128'd1);
      tick();
      chk("col_wb2", 128'(wb_valid), 128'd1);
      chk("col_wb2_addr", 128'(wb_rt_addr), 128'h02);
      tick();
      chk("col_wb_end", 128'(wb_valid), 128'd0);
      chk("col_cnt_end", 128'(inflight_count), 128'd0);

      // Illegal latency
      offer(4'd0, 7'h05, 128'd5, 1'b1);
      chk("ill0_ready", 128'(issue_ready), 128'd0);
      tick();
      chk("ill0_lat_err", 128'(lat_err), 128'd1);
      chk("ill0_cnt", 128'(inflight_count), 128'd0);
      offer(4'd9, 7'h05, 128'd5, 1'b1);
      chk("ill9_ready", 128'(issue_ready), 128'd0);
      tick(); issue_valid = 1'b0;
      chk("ill9_cnt", 128'(inflight_count), 128'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ill_no_wb", 128'(wb_valid), 128'd0);
      end
      chk("ill_sticky", 128'(lat_err), 128'd1);

      // Flush with a concurrent offer
      for (int i = 0; i < 3; i++) begin
         offer(4'd6, 7'(4 + i), 128'(16 + i), 1'b1);
         chk("fl_ready", 128'(issue_ready), 128'd1);
         tick();
      end
      chk("fl_cnt_pre", 128'(inflight_count), 128'd3);
      offer(4'd2, 7'h0A, 128'hAA, 1'b1);
      flush = 1'b1;
      #1;
      chk("fl_ready_low", 128'(issue_ready), 128'd0);
      tick(); flush = 1'b0; issue_valid = 1'b0;
      chk("fl_cnt", 128'(inflight_count), 128'd0);
      chk("fl_wb0", 128'(wb_valid), 128'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("fl_no_wb", 128'(wb_valid), 128'd0);
      end

      // Asynchronous reset with three live entries
      for (int i = 0; i < 3; i++) begin
         offer(4'd6, 7'(8 + i), 128'(32 + i), 1'b1);
         tick();
      end
      issue_valid = 1'b0;
      #2;
      chk("mr_cnt_pre", 128'(inflight_count), 128'd3);
      reset = 1'b1;
      #1;
      chk("mr_cnt", 128'(inflight_count), 128'd0);
      chk("mr_lat_err", 128'(lat_err), 128'd0);
      chk("mr_wb_valid", 128'(wb_valid), 128'd0);
      chk("mr_wb_addr", 128'(wb_rt_addr), 128'd0);
      chk("mr_wb_value", wb_rt_value, 128'd0);
      chk("mr_ready", 128'(issue_ready), 128'd0);
      @(negedge clock);
      reset = 1'b0;
      offer(4'd1, 7'h09, 128'h99, 1'b1);
      chk("mr_l1_ready", 128'(issue_ready), 128'd1);
      tick(); issue_valid = 1'b0;
      chk("mr_l1_wb", 128'(wb_valid), 128'd1);
      chk("mr_l1_addr", 128'(wb_rt_addr), 128'h09);
      chk("mr_l1_value", wb_rt_value, 128'h99);
      chk("mr_l1_cnt", 128'(inflight_count), 128'd0);
      tick();
      chk("mr_l1_end", 128'(wb_valid), 128'd0);

      // Forwarding: two live entries to addr 3, younger holds 2
      offer(4'd6, 7'h03, 128'd1, 1'b1);
      tick();
      offer(4'd6, 7'h03, 128'd2, 1'b1);
      tick(); issue_valid = 1'b0;
      fwd_addr = 7'h03;
      #1;
`ifdef ODDPIPE_WB_FWD_EN
      chk("fwd_hit", 128'(fwd_hit), 128'd1);
      chk("fwd_value", fwd_value, 128'd2);
`else
      chk("fwd_off_hit", 128'(fwd_hit), 128'd0);
      chk("fwd_off_value", fwd_value, 128'd0);
`endif
      fwd_addr = 7'h04;
      #1;
      chk("fwd_miss", 128'(fwd_hit), 128'd0);
      flush = 1'b1;
      tick(); flush = 1'b0;
      chk("fwd_flush_cnt", 128'(inflight_count), 128'd0);

      // reg_write low: no hit, no strobe, payload still driven
      offer(4'd3, 7'h03, 128'd7, 1'b0);
      tick();
      offer(4'd3, 7'h03, 128'd8, 1'b0);
      tick(); issue_valid = 1'b0;
      fwd_addr = 7'h03;
      #1;
      chk("rw0_fwd_hit", 128'(fwd_hit), 128'd0);
      tick();
      chk("rw0_wb1_valid", 128'(wb_valid), 128'd0);
      chk("rw0_wb1_value", wb_rt_value, 128'd7);
      chk("rw0_wb1_addr", 128'(wb_rt_addr), 128'h03);
      tick();
      chk("rw0_wb2_valid", 128'(wb_valid), 128'd0);
      chk("rw0_wb2_value", wb_rt_value, 128'd8);
      chk("rw0_cnt", 128'(inflight_count), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
